fp_mul_arbiter: RTL and testbench

- Shares one pipelined FP32 multiplier (`fp_mult` IP, fixed latency, no backpressure) between NUM_REQ requesters.
- Typical requesters are the force-pipeline stages of the MD kernel.
- Grants are round-robin, at most one operation per cycle.
- Each operand pair carries a requester-ID tag through a shadow pipeline that matches the multiplier latency. Each result is steered back to its originating requester.
- Flags any misalignment between the tag pipeline and the IP's result-valid.

---
 rtl/fp_mul_arbiter.sv | 155 +++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP32 multiplier between NUM_REQ requesters.
// A shadow tag pipeline steers each product back to its requester and flags tag/IP valid misalignment.
module fp_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 8,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [31:0]           mul_a,
   output logic [31:0]           mul_b,
   output logic                  mul_valid,
   input  logic [31:0]           mul_result,
   input  logic                  mul_result_valid,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_data,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  busy,
   output logic                  err
);
   localparam int CNT_W   = $clog2(MUL_LATENCY + 3);
   localparam int GUARD_W = $clog2(MUL_LATENCY + 2);
   localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(MUL_LATENCY + 1);

   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [31:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic               mul_valid_q, mul_valid_d;
   logic [ID_W-1:0]    iss_id_q, iss_id_d;
   logic [MUL_LATENCY-1:0]           tag_v_q, tag_v_d;
   logic [MUL_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [GUARD_W-1:0] guard_q, guard_d;
   logic               err_q, err_d;

   logic               grant_found, transfer, tag_out_v;
   logic [ID_W-1:0]    grant_idx, cand, tag_out_id;
   logic [31:0]        a_sel, b_sel;

   // Round-robin search starting at ptr_q; depends only on req_valid, never on operands.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
      transfer  = grant_found & ~rst;
      req_ready = transfer ? (NUM_REQ'(1) << grant_idx) : '0;
      a_sel     = '0;
      b_sel     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            a_sel = req_a[32*i +: 32];
            b_sel = req_b[32*i +: 32];
         end
      end
   end

   assign tag_out_v  = tag_v_q[MUL_LATENCY-1];
   assign tag_out_id = tag_id_q[MUL_LATENCY-1];

   always_comb begin
      ptr_d       = ptr_q;
      mul_valid_d = transfer;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      iss_id_d    = iss_id_q;
      if (transfer) begin
         ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
         mul_a_d  = a_sel;
         mul_b_d  = b_sel;
         iss_id_d = grant_idx;
      end

      tag_v_d     = '0;
      tag_id_d    = '0;
      tag_v_d[0]  = mul_valid_q;
      tag_id_d[0] = iss_id_q;
      for (int i = 1; i < MUL_LATENCY; i++) begin
         tag_v_d[i]  = tag_v_q[i-1];
         tag_id_d[i] = tag_id_q[i-1];
      end

      rsp_valid_d = tag_out_v ? (NUM_REQ'(1) << tag_out_id) : '0;
      rsp_data_d  = tag_out_v ? mul_result : rsp_data_q;
      rsp_id_d    = tag_out_v ? tag_out_id : rsp_id_q;

      cnt_d = cnt_q;
      case ({transfer, |rsp_valid_q})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      // The guard masks stale IP results still draining from before the last reset.
      guard_d = (guard_q != '0) ? guard_q - GUARD_W'(1) : guard_q;
      err_d   = err_q | ((guard_q == '0) & (tag_out_v != mul_result_valid));
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         ptr_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_valid_q <= 1'b0;
         iss_id_q    <= '0;
         // NOTE: the tag shift register is reset (unlike a data RAM) because its valid bits drop in-flight work.
         tag_v_q     <= '0;
         tag_id_q    <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         cnt_q       <= '0;
         guard_q     <= GUARD_INIT;
         err_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_valid_q <= mul_valid_d;
         iss_id_q    <= iss_id_d;
         tag_v_q     <= tag_v_d;
         tag_id_q    <= tag_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         cnt_q       <= cnt_d;
         guard_q     <= guard_d;
         err_q       <= err_d;
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_valid = mul_valid_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (cnt_q != '0);
   assign err       = err_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: directed vectors, a behavioural fixed-latency multiplier
// with adjustable latency, and a monitor that pops expected responses as the DUT emits them.
module tb_fp_mul_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int MUL_LATENCY = 8;
   localparam int ID_W        = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [32*NUM_REQ-1:0] req_a, req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic [31:0]           mul_a, mul_b, mul_result;
   logic                  mul_valid, mul_result_valid;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [31:0]           rsp_data;
   logic [ID_W-1:0]       rsp_id;
   logic                  busy, err;

   fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
      .mul_result(mul_result), .mul_result_valid(mul_result_valid),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Hand-computed IEEE-754 products for the directed operands; 1.0*x = x for the bulk traffic.
   function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (a == 32'h3FC00000 && b == 32'hC0800000) return 32'hC0C00000;
      if (a == 32'h00000000 && b == 32'h7F800000) return 32'h7FC00000;
      if (a == 32'h3F800000) return b;
      return 32'hDEADBEEF;
   endfunction

   // Behavioural IP: no reset, so results of dropped operations keep emerging.
   int          model_lat = MUL_LATENCY;
   logic [15:0] m_v = '0;
   logic [31:0] m_d [16];
   always @(posedge clk) begin
      m_v    <= {m_v[14:0], mul_valid};
      m_d[0] <= fp_ref(mul_a, mul_b);
      for (int i = 1; i < 16; i++) m_d[i] <= m_d[i-1];
   end
   assign mul_result_valid = m_v[model_lat-1];
   assign mul_result       = m_d[model_lat-1];

   typedef struct {
      int          id;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   bit          sb_enable = 1'b1;
   int          grant_log[$], grant_cyc[$];
   int          rsp_log_id[$], rsp_log_cyc[$];
   logic [31:0] rsp_log_data[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Acceptor: every handshake pushes the expected response and logs the grant.
   always @(negedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            if (sb_enable) sb_q.push_back('{id: i, data: fp_ref(req_a[32*i +: 32], req_b[32*i +: 32])});
            grant_log.push_back(i);
            grant_cyc.push_back(cyc);
         end
      end
   end

   // Monitor: any response strobe pops and compares one scoreboard entry.
   always @(negedge clk) begin
      if (sb_enable && rsp_valid != '0) begin
         rsp_log_id.push_back(int'(rsp_id));
         rsp_log_cyc.push_back(cyc);
         rsp_log_data.push_back(rsp_data);
         if (sb_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'h0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_data", rsp_data, e.data);
            check("rsp_onehot", 32'(rsp_valid), 32'(1) << e.id);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst       = 1'b1;
      req_valid = '0;
      tick();
      tick();
      rst = 1'b0;
      sb_q.delete();
   endtask

   task automatic clear_logs();
      grant_log.delete();
      grant_cyc.delete();
      rsp_log_id.delete();
      rsp_log_cyc.delete();
      rsp_log_data.delete();
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || busy) && n < 60) begin
         tick();
         n++;
      end
      check("drain_done", 32'(sb_q.size() == 0 && !busy), 32'h1);
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_a     = '0;
      req_b     = '0;
      tick();
      mid();
      check("ready_in_reset", 32'(req_ready), 32'h0);
      tick();
      req_valid = '0;
      tick();
      rst = 1'b0;
      mid();
      check("reset_mul_valid", 32'(mul_valid), 32'h0);
      check("reset_mul_a", mul_a, 32'h0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset_rsp_data", rsp_data, 32'h0);
      check("reset_rsp_id", 32'(rsp_id), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_err", 32'(err), 32'h0);
      check("idle_ready", 32'(req_ready), 32'h0);

      // Single op from requester 2: accept at c0, mul_valid at c0+1, response at c0+10.
      tick();
      set_req(2, 32'h40000000, 32'h40400000);
      req_valid = 4'b0100;
      mid();
      check("single_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      mid();
      check("single_mul_valid", 32'(mul_valid), 32'h1);
      check("single_mul_a", mul_a, 32'h40000000);
      check("single_mul_b", mul_b, 32'h40400000);
      check("single_busy_1", 32'(busy), 32'h1);
      for (int k = 2; k <= 11; k++) begin
         tick();
         mid();
         check($sformatf("single_busy_%0d", k), 32'(busy), 32'(k <= 10));
         if (k == 2) begin
            check("single_mul_valid_drop", 32'(mul_valid), 32'h0);
            check("single_mul_a_hold", mul_a, 32'h40000000);
         end
         if (k == 9) check("single_rsp_early", 32'(rsp_valid), 32'h0);
         if (k == 10) begin
            check("single_rsp_valid", 32'(rsp_valid), 32'h4);
            check("single_rsp_id", 32'(rsp_id), 32'h2);
            check("single_rsp_data", rsp_data, 32'h40C00000);
         end
      end
      drain();

      // Fairness: all four requesters valid for 12 cycles.
      reset_dut();
      clear_logs();
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h3F800000, 32'h41000000 | (k << 4) | i);
         req_valid = 4'b1111;
         tick();
      end
      req_valid = '0;
      drain();
      check("fair_grant_count", 32'(grant_log.size()), 32'd12);
      check("fair_rsp_count", 32'(rsp_log_id.size()), 32'd12);
      if (grant_log.size() == 12 && rsp_log_id.size() == 12) begin
         for (int k = 0; k < 12; k++) begin
            check($sformatf("fair_grant_%0d", k), 32'(grant_log[k]), 32'(k % 4));
            check($sformatf("fair_grant_cyc_%0d", k), 32'(grant_cyc[k] - grant_cyc[0]), 32'(k));
            check($sformatf("fair_rsp_id_%0d", k), 32'(rsp_log_id[k]), 32'(k % 4));
            check($sformatf("fair_rsp_cyc_%0d", k), 32'(rsp_log_cyc[k] - grant_cyc[k]), 32'(MUL_LATENCY + 2));
         end
      end

      // Sparse contention: requester 1 alone moves ptr to 2, then 1 and 3 compete.
      reset_dut();
      clear_logs();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h3F800000, 32'h42000000 | i);
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b1010;
      repeat (4) tick();
      req_valid = '0;
      drain();
      check("sparse_count", 32'(grant_log.size()), 32'd5);
      if (grant_log.size() == 5) begin
         for (int k = 1; k < 5; k++)
            check($sformatf("sparse_grant_%0d", k), 32'(grant_log[k]), (k % 2 == 1) ? 32'd3 : 32'd1);
      end

      // Back-to-back values: 1.5 * -4.0 from requester 0, then 0 * inf from requester 1.
      reset_dut();
      clear_logs();
      set_req(0, 32'h3FC00000, 32'hC0800000);
      req_valid = 4'b0001;
      tick();
      set_req(1, 32'h00000000, 32'h7F800000);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      drain();
      check("b2b_count", 32'(rsp_log_id.size()), 32'd2);
      if (rsp_log_id.size() == 2) begin
         check("b2b_id0", 32'(rsp_log_id[0]), 32'd0);
         check("b2b_data0", rsp_log_data[0], 32'hC0C00000);
         check("b2b_id1", 32'(rsp_log_id[1]), 32'd1);
         check("b2b_data1", rsp_log_data[1], 32'h7FC00000);
         check("b2b_spacing", 32'(rsp_log_cyc[1] - rsp_log_cyc[0]), 32'd1);
      end

      // Reset mid-flight: three ops, then a one-cycle reset four cycles after the first.
      reset_dut();
      for (int i = 0; i < 3; i++) set_req(i, 32'h3F800000, 32'h43000000 | i);
      req_valid = 4'b0111;
      repeat (3) tick();
      req_valid = '0;
      tick();
      rst = 1'b1;
      sb_q.delete();
      tick();
      rst = 1'b0;
      mid();
      check("rstmid_busy", 32'(busy), 32'h0);
      for (int k = 0; k < 14; k++) begin
         tick();
         mid();
         check($sformatf("rstmid_err_%0d", k), 32'(err), 32'h0);
         check($sformatf("rstmid_rsp_%0d", k), 32'(rsp_valid), 32'h0);
      end
      tick();
      set_req(0, 32'h3F800000, 32'h44000000);
      set_req(1, 32'h3F800000, 32'h44000001);
      set_req(2, 32'h3F800000, 32'h44000002);
      set_req(3, 32'h3F800000, 32'h44000003);
      req_valid = 4'b1111;
      mid();
      check("rstmid_ptr0", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      drain();

      // Misalignment: the IP runs one cycle slower than the tag pipeline.
      reset_dut();
      repeat (12) tick();
      sb_enable = 1'b0;
      model_lat = MUL_LATENCY + 1;
      set_req(0, 32'h3F800000, 32'h40000000);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      for (int k = 1; k <= 15; k++) begin
         mid();
         if (k == MUL_LATENCY + 1) check("mis_err_before", 32'(err), 32'h0);
         if (k >= MUL_LATENCY + 2) check($sformatf("mis_err_%0d", k), 32'(err), 32'h1);
         tick();
      end
      model_lat = MUL_LATENCY;
      reset_dut();
      sb_enable = 1'b1;
      mid();
      check("mis_err_cleared", 32'(err), 32'h0);
      tick();
      check("final_sb_empty", 32'(sb_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
